// File: rtl/dmem_arbiter.sv
// dmem_arbiter: serialises core and debug word accesses onto one single-port data memory.
// Define DMEM_ARB_RR_EN for round-robin arbitration; the default build uses fixed core-over-debug priority.
module dmem_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          c_ack,
  output logic          c_err,
  output logic          c_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          d_err,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic [1:0]    grant
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;

  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          win_q, win_d;      // transaction owner: 0 = core, 1 = debug
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          err_q, err_d;
  logic [1:0]    grant_q, grant_d;
  logic [DW-1:0] c_rdata_q, c_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

  logic          pick_dbg;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

`ifdef DMEM_ARB_RR_EN
  logic rr_q, rr_d;                 // tie-break pointer: 0 = core, 1 = debug

  assign pick_dbg = d_req & (~c_req | rr_q);

  // The pointer always lands on the port that did not just win.
  always_comb begin
    rr_d = rr_q;
    if (state_q == ST_IDLE && (c_req || d_req)) rr_d = ~pick_dbg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_q <= 1'b0;
    else      rr_q <= rr_d;
  end
`else
  assign pick_dbg = d_req & ~c_req;
`endif

  assign sel_we    = pick_dbg ? d_we    : c_we;
  assign sel_addr  = pick_dbg ? d_addr  : c_addr;
  assign sel_wdata = pick_dbg ? d_wdata : c_wdata;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    win_d     = win_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    grant_d   = grant_q;
    c_rdata_d = c_rdata_q;
    d_rdata_d = d_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (c_req || d_req) begin
          win_d   = pick_dbg;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          err_d   = |sel_addr[1:0];
          grant_d = pick_dbg ? 2'b10 : 2'b01;
          state_d = (|sel_addr[1:0]) ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = LAT_M1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd0) begin
          if (win_q) d_rdata_d = m_rdata;
          else       c_rdata_d = m_rdata;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_RESP: begin
        grant_d = 2'b00;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd0;
      win_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      grant_q   <= 2'b00;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge value of its peers.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      grant_q   <= grant_d;
      c_rdata_q <= c_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Outputs decode directly from registered state, so reset clears them without waiting for a clock.
  assign m_en    = (state_q == ST_ISSUE);
  assign m_we    = m_en & we_q;
  assign m_addr  = {addr_q[AW-1:2], 2'b00};
  assign m_wdata = wdata_q;

  assign c_ack   = (state_q == ST_RESP) & ~win_q;
  assign d_ack   = (state_q == ST_RESP) &  win_q;
  assign c_err   = c_ack & err_q;
  assign d_err   = d_ack & err_q;
  assign c_stall = c_req & ~c_ack;

  assign c_rdata = c_rdata_q;
  assign d_rdata = d_rdata_q;
  assign grant   = grant_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random two-port traffic against a transaction-level timing/memory model.
module tb_dmem_arbiter;

  localparam int MEM_LAT = 3;
  localparam int AW      = 32;
  localparam int DW      = 32;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          c_req, c_we, c_ack, c_err, c_stall;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic          d_req, d_we, d_ack, d_err;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata = '0;
  logic [1:0]    grant;

  dmem_arbiter #(.MEM_LAT(MEM_LAT), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_ack(c_ack), .c_err(c_err), .c_stall(c_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .grant(grant)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", tag, $time, obs, exp);
    end
  endtask

  // Memory responder: data appears MEM_LAT cycles after the strobe cycle, junk otherwise.
  logic [DW-1:0] mem [bit [AW-1:0]];
  int            rd_cnt = 0;
  logic [DW-1:0] rd_val = '0;
  int            n_strobes = 0;

  always @(posedge clk) begin
    if (m_en) begin
      n_strobes++;
      if (m_we) mem[m_addr] = m_wdata;
      else begin
        rd_cnt = MEM_LAT;
        rd_val = mem.exists(m_addr) ? mem[m_addr] : '0;
      end
    end else if (rd_cnt > 0) begin
      rd_cnt--;
    end
    m_rdata <= (rd_cnt == 1) ? rd_val : DW'($urandom);
  end

  // Reference model state
  typedef struct packed {
    logic          v;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  logic [DW-1:0] ref_mem [bit [AW-1:0]];
  logic [DW-1:0] exp_rdata [2] = '{default: '0};
  int            exp_strobes = 0;
  bit            rr_ptr = 1'b0;

  function automatic txn_t mk(input bit v, input bit we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata);
    txn_t t;
    t.v = v; t.we = we; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  function automatic int txn_len(input txn_t t);
    if (t.addr[1:0] != 2'b00) return 1;
    return t.we ? 2 : 2 + MEM_LAT;
  endfunction

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  task automatic release_port(input int p);
    if (p == 0) begin
      c_req = 1'b0; c_we = 1'($urandom); c_addr = AW'($urandom); c_wdata = DW'($urandom);
    end else begin
      d_req = 1'b0; d_we = 1'($urandom); d_addr = AW'($urandom); d_wdata = DW'($urandom);
    end
  endtask

  // Present one request per port (either may be absent) in the same IDLE cycle and
  // check every cycle until both complete. Index 0 = core, 1 = debug.
  task automatic run_pair(input txn_t ct, input txn_t dt);
    txn_t          t [2];
    int            s [2];
    int            a [2];
    int            first, second, last_k, sp;
    logic [DW-1:0] rd_exp [2];
    logic          gnt_e [2];
    logic          ack_e [2];
    logic          err_e [2];
    logic          men_e, mwe_e, stall_e;
    t[0] = ct; t[1] = dt;
    s = '{-10, -10}; a = '{-10, -10};
    rd_exp = '{default: '0};
    first = -1; last_k = 0;
    if (t[0].v && t[1].v) first = (RR_EN && rr_ptr) ? 1 : 0;
    else if (t[0].v)      first = 0;
    else if (t[1].v)      first = 1;
    if (first >= 0) begin
      s[first] = 0;
      a[first] = txn_len(t[first]);
      last_k   = a[first];
      rr_ptr   = (first == 0);
      second   = 1 - first;
      if (t[second].v) begin
        s[second] = a[first] + 1;
        a[second] = s[second] + txn_len(t[second]);
        last_k    = a[second];
        rr_ptr    = (second == 0);
      end
    end

    @(negedge clk);
    c_req = t[0].v; c_we = t[0].we; c_addr = t[0].addr; c_wdata = t[0].wdata;
    d_req = t[1].v; d_we = t[1].we; d_addr = t[1].addr; d_wdata = t[1].wdata;

    for (int k = 0; k <= last_k; k++) begin
      if (k > 0) @(negedge clk);
      else       #1;
      men_e = 1'b0; mwe_e = 1'b0; sp = 0;
      for (int p = 0; p < 2; p++) begin
        gnt_e[p] = t[p].v && k > s[p] && k <= a[p];
        ack_e[p] = t[p].v && k == a[p];
        err_e[p] = ack_e[p] && t[p].addr[1:0] != 2'b00;
        if (t[p].v && t[p].addr[1:0] == 2'b00 && k == s[p] + 1) begin
          men_e = 1'b1; mwe_e = t[p].we; sp = p;
        end
      end
      stall_e = t[0].v && k < a[0];
      check("ctl", {grant, c_ack, c_err, d_ack, d_err, m_en, m_we, c_stall},
            {gnt_e[1], gnt_e[0], ack_e[0], err_e[0], ack_e[1], err_e[1], men_e, mwe_e, stall_e});
      if (men_e) begin
        exp_strobes++;
        check("m_addr", m_addr, {t[sp].addr[AW-1:2], 2'b00});
        if (t[sp].we) begin
          check("m_wdata", m_wdata, t[sp].wdata);
          ref_mem[{t[sp].addr[AW-1:2], 2'b00}] = t[sp].wdata;
        end else begin
          rd_exp[sp] = ref_read({t[sp].addr[AW-1:2], 2'b00});
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (ack_e[p]) begin
          if (t[p].addr[1:0] == 2'b00 && !t[p].we) exp_rdata[p] = rd_exp[p];
          if (p == 0) check("c_rdata", c_rdata, exp_rdata[0]);
          else        check("d_rdata", d_rdata, exp_rdata[1]);
          release_port(p);
        end
      end
    end
  endtask

  task automatic reset_mid_read(input logic [AW-1:0] addr);
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = addr; d_wdata = DW'($urandom);
    @(negedge clk);
    check("rst_issue", {grant, m_en, m_we}, {2'b10, 1'b1, 1'b0});
    exp_strobes++;
    @(negedge clk);
    check("rst_wait", {grant, m_en, d_ack}, {2'b10, 1'b0, 1'b0});
    rst = 1'b0;
    d_req = 1'b0;
    #1;
    check("rst_ctl", {grant, c_ack, c_err, d_ack, d_err, m_en, m_we, c_stall}, '0);
    check("rst_rdata", {c_rdata, d_rdata}, '0);
    check("rst_mbus", {m_addr, m_wdata}, '0);
    exp_rdata = '{default: '0};
    rr_ptr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_pair(mk(0, 0, '0, '0), mk(1, 0, addr, '0));
  endtask

  txn_t idle_t;
  txn_t rt [2];

  initial begin
    idle_t = mk(0, 0, '0, '0);
    rst = 1'b0;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    check("reset_ctl", {grant, c_ack, c_err, d_ack, d_err, m_en, m_we, c_stall}, '0);
    check("reset_rdata", {c_rdata, d_rdata}, '0);
    check("reset_mbus", {m_addr, m_wdata}, '0);
    rst = 1'b1;

    run_pair(mk(1, 1, 32'h40, 32'hDEADBEEF), idle_t);
    run_pair(mk(1, 0, 32'h40, 32'h0), idle_t);
    run_pair(idle_t, mk(1, 1, 32'h10, 32'h11112222));
    run_pair(idle_t, mk(1, 1, 32'h20, 32'h33334444));
    run_pair(mk(1, 0, 32'h10, 32'h0), mk(1, 0, 32'h20, 32'h0));
    run_pair(idle_t, mk(1, 1, 32'h04, 32'hCAFEF00D));
    run_pair(idle_t, mk(1, 1, 32'h06, 32'hBAD0BAD0));
    run_pair(idle_t, mk(1, 0, 32'h04, 32'h0));
    run_pair(idle_t, mk(1, 1, 32'hCC, 32'h12345678));
    run_pair(idle_t, mk(1, 0, 32'hCC, 32'h0));
    run_pair(mk(1, 0, 32'h41, 32'h0), mk(1, 1, 32'h44, 32'h5555AAAA));
    run_pair(mk(1, 1, 32'h48, 32'h0BADCAFE), mk(1, 0, 32'h48, 32'h0));

    for (int i = 0; i < 150; i++) begin
      for (int p = 0; p < 2; p++) begin
        rt[p].v     = ($urandom_range(0, 9) < 7);
        rt[p].we    = 1'($urandom);
        rt[p].addr  = AW'($urandom_range(0, 15)) << 2;
        if ($urandom_range(0, 9) == 0) rt[p].addr[1:0] = 2'($urandom_range(1, 3));
        rt[p].wdata = DW'($urandom);
      end
      run_pair(rt[0], rt[1]);
    end

    reset_mid_read(32'hCC);
    @(negedge clk);
    check("strobes", 128'(n_strobes), 128'(exp_strobes));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer sharing the single-port data memory between the MIPS core's load/store path and a debug/loader port (program preload, stack dump, host-side inspection). Accepts word requests from both sides, serialises them onto the memory port, counts out the memory read latency, and returns data with a one-cycle acknowledge. Sits between `MIPS_Core`'s `mem_addr`/`mem_wdata`/`mem_rdata` signals and `dmem`. It drives a stall to the core while a core access is outstanding.

## Interface
- `MEM_LAT`, 1: cycles from an `m_en` read cycle to valid `m_rdata`; legal range 1..7.
- `AW`, 32: address width.
- `DW`, 32: data width.

- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `c_req`, `c_we`  in  1  core request (level) and write select.
- `c_addr`  in  AW  core byte address.
- `c_wdata`  in  DW  core store data.
- `c_rdata`  out  DW  core load data, registered, valid with `c_ack`.
- `c_ack`, `c_err`  out  1  core completion pulse and misalignment error pulse.
- `c_stall`  out  1  `c_req & ~c_ack`; combinational.
- `d_req`, `d_we`, `d_addr`, `d_wdata`, `d_rdata`, `d_ack`, `d_err`: same widths and meanings for the debug port.
- `m_en`, `m_we`  out  1  memory strobe and write enable.
- `m_addr`  out  AW  word-aligned address (`[1:0]` = 0).
- `m_wdata`  out  DW  store data.
- `m_rdata`  in  DW  memory read data.
- `grant`  out  2  one-hot owner of the current transaction: bit0 = core, bit1 = debug. 00 when idle.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT and RESP. A 3-bit latency counter runs alongside it.
- **IDLE**
  - Requests are sampled here only.
  - On any request, the arbiter picks a winner and latches that requester's `we`, `addr` and `wdata`.
  - It then sets `grant`.
  - If `addr[1:0]≠0`, the FSM goes straight to RESP with the error flag set. No memory access takes place.
  - Otherwise the FSM goes to ISSUE.
- **ISSUE**
  - `m_en`=1 for exactly one cycle, with the latched address, data and `we`.
  - For a write, the FSM goes to RESP.
  - For a read, the FSM goes to WAIT and the counter loads `MEM_LAT-1`.
- **WAIT**
  - If the counter is 0, `m_rdata` is captured into the winner's rdata register and the FSM goes to RESP.
  - Otherwise the counter decrements.
- **RESP**
  - The winner's `ack` is high for one cycle; its `err` is high too if the misalignment flag is set.
  - `grant` clears and the FSM goes to IDLE.
- Rdata registers hold their value until the next read completes on that port.
- Writes and errors leave `rdata` unchanged.
- Requesters hold `req` and their fields stable until `ack`.
  - A `req` still high in the cycle after `ack` is treated as a new transaction.
  - Back-to-back transactions are legal.
- `m_en`/`m_we` are 0 outside ISSUE. `m_addr`/`m_wdata` hold the latched values.
- Arbitration policy: fixed priority, core over debug, unless the round-robin feature in Configuration is compiled in.

## Timing
- Let T be the first IDLE cycle with `req` high.
- Write: `m_en` at T+1, `ack` at T+2.
- Read: `m_en` at T+1, data captured at T+1+MEM_LAT, `ack` at T+2+MEM_LAT. With MEM_LAT=1, `ack` is at T+3.
- Misaligned access: `ack`+`err` at T+1.
- The losing requester waits, stalled if it is the core. Its earliest grant is the IDLE cycle after the winner's RESP.
- Reset values: every output is 0; the FSM is in IDLE; the counter and RR pointer are 0 (core).
- Reset asserted mid-transaction:
  - The FSM returns to IDLE immediately.
  - No `ack` is issued; the requester must reissue.
  - A write already strobed in ISSUE is committed by memory. A read is discarded.
- A `req` deasserted before `ack` is a protocol violation. The transaction still completes and the `ack` pulse is dropped by the requester.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin arbitration.
  - On a simultaneous request, the port indicated by a 1-bit pointer wins.
  - After each grant the pointer moves to the other port.
  - A lone requester always wins.
- `DMEM_ARB_RR_EN` undefined: fixed priority. The core always wins a tie and the pointer logic is absent.

## Test plan
- **Core write then read, no debug traffic, MEM_LAT=1:**
  - Stimulus: core writes 0xDEADBEEF to 0x0040, then reads 0x0040.
  - Write: `m_en`/`m_we` at T+1, `c_ack` at T+2.
  - Read: `c_ack` at T+3 with `c_rdata`=0xDEADBEEF; `c_stall` is high through T+2.
- **Simultaneous requests, fixed priority:** core reads 0x0010 while debug reads 0x0020. Core `ack` comes first, then debug. `grant` sequence is 01 → 00 → 10.
- **Simultaneous requests, `DMEM_ARB_RR_EN` defined, both `req` held high for 4 transactions:** grants alternate core, debug, core, debug.
- **Misaligned access:** debug write to 0x0006 gives `d_ack`+`d_err` at T+1. `m_en` is never asserted and memory is unchanged.
- **MEM_LAT=3:** debug reads 0x00CC holding 0x12345678. `d_ack` at T+5 with `d_rdata`=0x12345678.
- **Reset mid-read:** `rst` driven low during WAIT. All outputs go to 0 asynchronously. After release, the reissued read completes normally.
